// File: rtl/switch_port.sv
// Memory-mapped switch input port: synchronises and debounces the board switches into a data register,
// with a sticky new-data/overrun status word. Optional interrupt output and mask under SWITCH_PORT_IRQ_EN.
module switch_port #(
    parameter int WORD_W     = 8,
    parameter int OP_W       = 3,
    parameter int DEB_CYCLES = 16,
    parameter int DATA_ADDR  = 2**(WORD_W-OP_W)-1,
    parameter int STAT_ADDR  = 2**(WORD_W-OP_W)-3
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic [WORD_W-1:0]        switches,
    input  logic [WORD_W-OP_W-1:0]   Daddress,
    input  logic                     RE,
`ifdef SWITCH_PORT_IRQ_EN
    input  logic                     WE,
    input  logic [WORD_W-1:0]        Wdata,
    output logic                     irq,
`endif
    output logic [WORD_W-1:0]        Sdata,
    output logic                     sel
);

    localparam int ADDR_W = WORD_W - OP_W;
    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam logic [ADDR_W-1:0] DATA_A  = DATA_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] STAT_A  = STAT_ADDR[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WORD_W-1:0] sw_s1;
    logic [WORD_W-1:0] sw_s2;
    logic [WORD_W-1:0] cand;
    logic [WORD_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic              new_f;
    logic              ovr_f;
    logic              commit;
    logic              data_rd;
    logic [WORD_W-1:0] status_word;

    // Commit only once the candidate has been stable long enough and actually differs from the register.
    assign commit  = (sw_s2 == cand) && (cnt == CNT_MAX) && (cand != data_q);
    assign data_rd = RE && (Daddress == DATA_A);

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            cand   <= '0;
            data_q <= '0;
            cnt    <= '0;
            new_f  <= 1'b0;
            ovr_f  <= 1'b0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;

            if (sw_s2 != cand) begin
                cand <= sw_s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            // A read landing on the commit edge returns the old word but still sees the new one as fresh.
            if (commit) begin
                data_q <= cand;
                new_f  <= 1'b1;
                if (data_rd) begin
                    ovr_f <= 1'b0;
                end else if (new_f) begin
                    ovr_f <= 1'b1;
                end
            end else if (data_rd) begin
                new_f <= 1'b0;
                ovr_f <= 1'b0;
            end
        end
    end

`ifdef SWITCH_PORT_IRQ_EN
    logic irq_mask;
    logic new_f_q;

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            irq_mask <= 1'b1;
            new_f_q  <= 1'b0;
        end else begin
            new_f_q <= new_f;
            if (WE && (Daddress == STAT_A)) begin
                irq_mask <= Wdata[2];
            end
        end
    end

    assign irq = new_f_q & ~irq_mask;
`endif

    always_comb begin
        status_word    = '0;
        status_word[0] = new_f;
        status_word[1] = ovr_f;
`ifdef SWITCH_PORT_IRQ_EN
        status_word[2] = irq_mask;
`endif
    end

    always_comb begin
        Sdata = '0;
        sel   = 1'b0;
        if (Daddress == DATA_A) begin
            Sdata = data_q;
            sel   = 1'b1;
        end else if (Daddress == STAT_A) begin
            Sdata = status_word;
            sel   = 1'b1;
        end
    end

endmodule

// File: tb/tb_switch_port.sv
// Self-checking bench for switch_port with DEB_CYCLES=4: reset, bounce rejection, overrun,
// read/commit collision, address decode table, optional irq, and reset mid-debounce.
module tb_switch_port;

    localparam int DEB = 4;

    logic       clock    = 1'b0;
    logic       n_reset  = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [4:0] Daddress = 5'd0;
    logic       RE       = 1'b0;
    logic [7:0] Sdata;
    logic       sel;
`ifdef SWITCH_PORT_IRQ_EN
    logic       WE    = 1'b0;
    logic [7:0] Wdata = 8'h00;
    logic       irq;
    logic [7:0] mask_exp = 8'h04;
`else
    logic [7:0] mask_exp = 8'h00;
`endif

    always #5 clock = ~clock;

    switch_port #(.WORD_W(8), .OP_W(3), .DEB_CYCLES(DEB)) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .switches (switches),
        .Daddress (Daddress),
        .RE       (RE),
`ifdef SWITCH_PORT_IRQ_EN
        .WE       (WE),
        .Wdata    (Wdata),
        .irq      (irq),
`endif
        .Sdata    (Sdata),
        .sel      (sel)
    );

    typedef struct {
        logic [4:0] addr;
        logic       re;
        logic [7:0] exp_data;
        logic       exp_sel;
    } vec_t;

    vec_t       vecs[9];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] st(input logic [7:0] v);
        return v | mask_exp;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Look at a register without a load strobe; no clock edge consumed.
    task automatic peek(input string name, input logic [4:0] addr, input logic [7:0] exp);
        Daddress = addr;
        RE       = 1'b0;
        exp_q.push_back(exp);
        #1;
        check(name, Sdata, exp_q.pop_front());
    endtask

    // Data load: value seen before the edge, then the edge that performs the read.
    task automatic rd_data(input string name, input logic [7:0] exp);
        Daddress = 5'd31;
        RE       = 1'b1;
        exp_q.push_back(exp);
        #1;
        check(name, Sdata, exp_q.pop_front());
        @(negedge clock);
        RE = 1'b0;
    endtask

    initial begin
        // 1. reset with switches already set
        switches = 8'hA5;
        step(2);
        peek("rst_data", 5'd31, 8'h00);
        peek("rst_status", 5'd29, st(8'h00));
        @(negedge clock);
        n_reset = 1'b1;
        step(6);
        peek("rst_no_early", 5'd29, st(8'h00));
        step(1);
        peek("rst_status_new", 5'd29, st(8'h01));
        peek("rst_data_a5", 5'd31, 8'hA5);

        // 2. bounce rejection
        rd_data("rd_a5", 8'hA5);
        for (int i = 0; i < 10; i++) begin
            switches = i[0] ? 8'h00 : 8'h3C;
            step(2);
            peek($sformatf("bounce%0d_status", i), 5'd29, st(8'h00));
        end
        switches = 8'h3C;
        step(6);
        peek("bounce_no_early", 5'd29, st(8'h00));
        step(1);
        peek("bounce_status", 5'd29, st(8'h01));
        peek("bounce_data", 5'd31, 8'h3C);

        // 3. overrun
        rd_data("rd_3c", 8'h3C);
        peek("clr_status", 5'd29, st(8'h00));
        switches = 8'h11;
        step(7);
        peek("ovr_first", 5'd29, st(8'h01));
        switches = 8'h22;
        step(7);
        peek("ovr_status", 5'd29, st(8'h03));
        rd_data("ovr_rd", 8'h22);
        peek("ovr_cleared", 5'd29, st(8'h00));

        // 4. read colliding with commit; new_f already set so ovr must still end at 0
        switches = 8'h11;
        step(7);
        peek("col_pre_data", 5'd31, 8'h11);
        peek("col_pre_status", 5'd29, st(8'h01));
        switches = 8'h55;
        step(6);
        rd_data("col_old_data", 8'h11);
        peek("col_new_data", 5'd31, 8'h55);
        peek("col_status", 5'd29, st(8'h01));

        // 5. decode table
        vecs[0] = '{5'd30, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{5'd29, 1'b1, st(8'h01), 1'b1};
        vecs[2] = '{5'd29, 1'b1, st(8'h01), 1'b1};
        vecs[3] = '{5'd28, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{5'd0,  1'b0, 8'h00, 1'b0};
        vecs[5] = '{5'd31, 1'b0, 8'h55, 1'b1};
        vecs[6] = '{5'd29, 1'b0, st(8'h01), 1'b1};
        vecs[7] = '{5'd31, 1'b1, 8'h55, 1'b1};
        vecs[8] = '{5'd29, 1'b0, st(8'h00), 1'b1};
        for (int i = 0; i < 9; i++) begin
            Daddress = vecs[i].addr;
            RE       = vecs[i].re;
            exp_q.push_back(vecs[i].exp_data);
            #1;
            check($sformatf("vec%0d_sdata", i), Sdata, exp_q.pop_front());
            check($sformatf("vec%0d_sel", i), {7'b0, sel}, {7'b0, vecs[i].exp_sel});
            @(negedge clock);
            RE = 1'b0;
        end

`ifdef SWITCH_PORT_IRQ_EN
        // 6. interrupt follows new_f one edge later once unmasked
        check("irq_masked", {7'b0, irq}, 8'h00);
        Daddress = 5'd29;
        Wdata    = 8'h00;
        WE       = 1'b1;
        @(negedge clock);
        WE       = 1'b0;
        mask_exp = 8'h00;
        peek("irq_unmasked", 5'd29, st(8'h00));
        switches = 8'h77;
        step(7);
        peek("irq_new", 5'd29, st(8'h01));
        check("irq_lag", {7'b0, irq}, 8'h00);
        step(1);
        check("irq_set", {7'b0, irq}, 8'h01);
        rd_data("irq_rd", 8'h77);
        check("irq_hold", {7'b0, irq}, 8'h01);
        step(1);
        check("irq_clr", {7'b0, irq}, 8'h00);
`endif

        // 7. reset mid-debounce discards the pending value, then it recommits
        switches = 8'h99;
        step(3);
        n_reset = 1'b0;
        step(1);
        n_reset  = 1'b1;
        mask_exp = 8'h00;
`ifdef SWITCH_PORT_IRQ_EN
        mask_exp = 8'h04;
`endif
        peek("mid_rst_data", 5'd31, 8'h00);
        peek("mid_rst_status", 5'd29, st(8'h00));
        step(6);
        peek("mid_rst_no_early", 5'd31, 8'h00);
        step(1);
        peek("mid_rst_data_99", 5'd31, 8'h99);
        peek("mid_rst_status_new", 5'd29, st(8'h01));

        check("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
